hls_ctrl_hs_initiator: RTL and testbench
========================================

Name: hls_ctrl_hs_initiator

Overview:
- Initiator side of the HLS ap_ctrl_hs block-level handshake. Drives ap_start into a key-locked HLS core such as sum_array, captures ap_return on ap_done, and hands the result back to a host over a valid/ready channel.
- Measures run latency in cycles, optionally compares the result against an expected golden value, and flags hung cores with a timeout.
- Sits between the test/host fabric and any obfuscated HLS core wrapper.

Parameters:
- DATA_W, 32, width of core_return, cmd_expected and res_data.
- CYC_W, 16, width of the latency counter. The counter saturates at 2^CYC_W-1.
- TIMEOUT, 4096, cycles allowed from start assertion to ap_done. 0 disables the timeout.

Ports:
- ap_clk  in  1  clock; all logic on the rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  host requests one core run.
- cmd_ready  out  1  initiator accepts a command.
- cmd_check  in  1  enable golden comparison for this run.
- cmd_expected  in  DATA_W  golden value for the comparison.
- core_start  out  1  drives the core's ap_start.
- core_ready  in  1  core's ap_ready.
- core_done  in  1  core's ap_done.
- core_idle  in  1  core's ap_idle.
- core_return  in  DATA_W  core's ap_return; valid only while core_done=1.
- res_valid  out  1  result available.
- res_ready  in  1  host consumes the result.
- res_data  out  DATA_W  captured core_return; 0 on timeout.
- res_cycles  out  CYC_W  run latency.
- res_mismatch  out  1  cmd_check=1 and res_data differs from cmd_expected.
- res_timeout  out  1  run aborted by timeout.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (async assert, synchronous release): state=IDLE. All outputs 0 except cmd_ready, which follows its combinational definition. Counter cleared. Reset mid-run drops core_start immediately and discards any pending result.
- cmd_ready = (state==IDLE) & core_idle. A command is accepted on cmd_valid & cmd_ready. cmd_check and cmd_expected are latched on acceptance.
- FSM states: IDLE, START, WAIT_DONE, RESP.
- IDLE -> START on accept. Counter loads 1 on that edge.
- START: core_start=1.
  - core_ready & core_done in the same cycle: capture the result and go to RESP.
  - core_ready only: go to WAIT_DONE; core_start falls the next cycle.
  - core_start is held until core_ready, per ap_ctrl_hs.
- WAIT_DONE: core_start=0. On core_done, capture core_return into res_data and go to RESP.
- The counter increments every cycle in START and WAIT_DONE, saturating at 2^CYC_W-1. res_cycles = cycles from the first core_start=1 cycle through the done cycle, inclusive. Example: start high 1 cycle, ready and done in that same cycle gives res_cycles=1.
- Timeout (TIMEOUT≠0): if the counter equals TIMEOUT in START or WAIT_DONE without core_done, go to RESP with res_timeout=1, res_data=0, res_mismatch=0, res_cycles=TIMEOUT. core_start is deasserted. A core_done in that same cycle takes priority: normal capture, no timeout.
- res_mismatch is registered at capture time as cmd_check & (core_return != cmd_expected).
- RESP: res_valid=1; res_data, res_cycles and the flags are stable. Leave to IDLE on res_ready.
  - res_valid drops the cycle after the handshake.
  - The next command cannot be accepted in the handshake cycle, so there is a minimum 1-cycle IDLE gap.
- While in RESP, core_done and core_ready pulses are ignored. No double capture.
- The core is never restarted while core_idle=0.

Test Plan:
- Normal run: core asserts ready on start cycle 1 and done 10 cycles later with return 0x00000037; cmd_check=1, expected 0x37 -> res_data=0x37, res_cycles=11, mismatch=0, timeout=0.
- Wrong key: same run, core returns 0x1234ABCD, expected 0x37 -> res_mismatch=1, res_data=0x1234ABCD. With cmd_check=0 the same run gives res_mismatch=0.
- Same-cycle ready+done on the first start cycle with return 0xFFFFFFFF -> core_start high exactly 1 cycle, res_cycles=1, and RESP entered directly without passing through WAIT_DONE.
- Hung core: TIMEOUT=4096, core never asserts done -> res_timeout=1 with res_cycles=4096, res_data=0, and core_start=0 after abort. Done at cycle 4096 -> normal capture instead.
- Back-pressure: hold res_ready=0 for 20 cycles and pulse core_done twice meanwhile -> outputs stable, no recapture. cmd_ready=0 until one cycle after the res handshake; cmd_ready also stays 0 while core_idle=0.
- Reset mid-run: deassert ap_rst_n during WAIT_DONE -> core_start, res_valid and busy are 0 immediately. After release, a new command runs normally.

Source files
------------

// File: rtl/hls_ctrl_hs_initiator.sv
// Purpose: ap_ctrl_hs initiator. It starts an HLS core, captures ap_return on ap_done, measures latency and flags a mismatch or a timeout.
// Latency: core_start rises 1 cycle after cmd accept. res_valid rises 1 cycle after the done or timeout cycle.
// Backpressure: the result is held in RESP until res_ready. No new command is taken until the cycle after the handshake.
//
// Ports:
//   ap_clk, ap_rst_n                    clock, async active-low reset (release assumed synchronous to ap_clk)
//   cmd_valid/cmd_ready                 host run request; cmd_check/cmd_expected latched on accept
//   core_start/ready/done/idle/return   ap_ctrl_hs signals of the core
//   res_valid/res_ready                 result channel; res_data, res_cycles, res_mismatch, res_timeout
//   busy                                FSM is not IDLE
module hls_ctrl_hs_initiator #(
    parameter int DATA_W  = 32,
    parameter int CYC_W   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_check,
    input  logic [DATA_W-1:0] cmd_expected,
    output logic              core_start,
    input  logic              core_ready,
    input  logic              core_done,
    input  logic              core_idle,
    input  logic [DATA_W-1:0] core_return,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [CYC_W-1:0]  res_cycles,
    output logic              res_mismatch,
    output logic              res_timeout,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    // A TIMEOUT the counter can never reach (beyond saturation) behaves as disabled.
    localparam bit               TO_EN  = (TIMEOUT > 0) &&
                                          (longint'(TIMEOUT) <= ((longint'(1) << CYC_W) - 1));
    localparam logic [CYC_W-1:0] TO_CNT = CYC_W'(TIMEOUT);

    state_t              r_state;
    logic                r_chk;
    logic [DATA_W-1:0]   r_exp;
    logic [CYC_W-1:0]    r_cnt;
    logic                r_core_start;
    logic                r_res_valid;
    logic                r_busy;
    logic [DATA_W-1:0]   r_res_data;
    logic [CYC_W-1:0]    r_res_cycles;
    logic                r_mismatch;
    logic                r_timeout;

    logic                w_accept;
    logic                w_running;
    logic                w_capture;
    logic                w_abort;
    logic [CYC_W-1:0]    w_cnt_inc;

    assign cmd_ready = (r_state == S_IDLE) & core_idle;
    assign w_accept  = cmd_valid & cmd_ready;
    assign w_running = (r_state == S_START) | (r_state == S_WAIT_DONE);

    // A done seen while still in START implies that the core consumed the start
    // (the ready+done case in the same cycle). That is why done alone triggers capture in both run states.
    assign w_capture = w_running & core_done;
    // When done arrives in the timeout cycle, done wins.
    assign w_abort   = w_running & TO_EN & (r_cnt == TO_CNT) & ~core_done;
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CYC_W'(1);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state      <= S_IDLE;
            r_chk        <= 1'b0;
            r_exp        <= '0;
            r_cnt        <= '0;
            r_core_start <= 1'b0;
            r_res_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_res_data   <= '0;
            r_res_cycles <= '0;
            r_mismatch   <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_chk        <= cmd_check;
                        r_exp        <= cmd_expected;
                        r_cnt        <= CYC_W'(1);
                        r_core_start <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= S_START;
                    end
                end
                S_START, S_WAIT_DONE: begin
                    if (w_capture || w_abort) begin
                        // The counter already holds the inclusive latency of this cycle.
                        r_res_data   <= w_capture ? core_return : '0;
                        r_res_cycles <= r_cnt;
                        r_mismatch   <= w_capture & r_chk & (core_return != r_exp);
                        r_timeout    <= w_abort;
                        r_res_valid  <= 1'b1;
                        r_core_start <= 1'b0;
                        r_state      <= S_RESP;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        // ap_start is held until the core acknowledges with ap_ready.
                        if (r_state == S_START && core_ready) begin
                            r_core_start <= 1'b0;
                            r_state      <= S_WAIT_DONE;
                        end
                    end
                end
                S_RESP: begin
                    // Core pulses are ignored here, so the held result cannot be overwritten.
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign core_start   = r_core_start;
    assign res_valid    = r_res_valid;
    assign res_data     = r_res_data;
    assign res_cycles   = r_res_cycles;
    assign res_mismatch = r_mismatch;
    assign res_timeout  = r_timeout;
    assign busy         = r_busy;

endmodule

// File: tb/tb_hls_ctrl_hs_initiator.sv
// Purpose: self-checking bench for hls_ctrl_hs_initiator, with a table of runs and a result scoreboard.
// Latency: inputs are driven 1 time unit after the rising edge, and the scoreboard samples on the falling edge.
// Backpressure: res_ready is high by default. It is held low in the back-pressure sequence.
module tb_hls_ctrl_hs_initiator;

    localparam int DW = 32;
    localparam int CW = 16;
    localparam int TO = 4096;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n;
    logic          cmd_valid, cmd_ready, cmd_check;
    logic [DW-1:0] cmd_expected;
    logic          core_start, core_ready, core_done, core_idle;
    logic [DW-1:0] core_return;
    logic          res_valid, res_ready;
    logic [DW-1:0] res_data;
    logic [CW-1:0] res_cycles;
    logic          res_mismatch, res_timeout, busy;

    always #5 ap_clk = ~ap_clk;

    hls_ctrl_hs_initiator #(.DATA_W(DW), .CYC_W(CW), .TIMEOUT(TO)) dut (
        .ap_clk       (ap_clk),
        .ap_rst_n     (ap_rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_check    (cmd_check),
        .cmd_expected (cmd_expected),
        .core_start   (core_start),
        .core_ready   (core_ready),
        .core_done    (core_done),
        .core_idle    (core_idle),
        .core_return  (core_return),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_cycles   (res_cycles),
        .res_mismatch (res_mismatch),
        .res_timeout  (res_timeout),
        .busy         (busy)
    );

    // One run: the command, the core behaviour (cycle index k=1 is the first start cycle), and the expected result.
    typedef struct {
        logic          chk;
        logic [DW-1:0] exp_in;
        logic [DW-1:0] ret;
        int            rdy_at;    // k where ready is asserted (0 = never)
        int            done_at;   // k where done is asserted
        bit            hang;      // done never asserted
        logic [DW-1:0] e_data;
        int            e_cycles;
        bit            e_mm;
        bit            e_to;
        int            e_starts;  // cycles with core_start high
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [CW-1:0] cycles;
        bit            mm;
        bit            to;
    } res_t;

    res_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge ap_clk);
        #1;
    endtask

    // Result monitor: each handshake pops one expected record from the scoreboard.
    always @(negedge ap_clk) begin : mon
        res_t e;
        if (ap_rst_n && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected: result 0x%0h with no expected entry", res_data);
            end else begin
                e = sb.pop_front();
                chk("sb_res_data", res_data, e.data);
                chk("sb_res_cycles", res_cycles, e.cycles);
                chk("sb_res_mismatch", res_mismatch, e.mm);
                chk("sb_res_timeout", res_timeout, e.to);
            end
        end
    end

    // Issues a command, plays the core side, and returns in the RESP cycle.
    task automatic run(input vec_t v, input string name);
        int   k;
        int   starts;
        bit   fin;
        res_t e;
        cmd_valid    = 1'b1;
        cmd_check    = v.chk;
        cmd_expected = v.exp_in;
        chk($sformatf("%s_cmd_ready", name), cmd_ready, 1);
        cyc();
        cmd_valid    = 1'b0;
        cmd_check    = 1'b0;
        cmd_expected = $urandom;
        e.data   = v.e_data;
        e.cycles = CW'(v.e_cycles);
        e.mm     = v.e_mm;
        e.to     = v.e_to;
        sb.push_back(e);
        core_idle = 1'b0;
        starts = 0;
        k      = 1;
        fin    = 1'b0;
        while (!fin) begin
            if (core_start) starts++;
            core_ready  = (k == v.rdy_at);
            core_done   = !v.hang && (k == v.done_at);
            core_return = core_done ? v.ret : $urandom;
            if (core_done || k >= TO) fin = 1'b1;
            cyc();
            k++;
        end
        core_ready  = 1'b0;
        core_done   = 1'b0;
        core_return = $urandom;
        core_idle   = 1'b1;
        chk($sformatf("%s_start_cycles", name), starts, v.e_starts);
        chk($sformatf("%s_res_valid", name), res_valid, 1);
        chk($sformatf("%s_core_start_off", name), core_start, 0);
    endtask

    task automatic do_vec(input vec_t v, input string name);
        run(v, name);
        cyc();
        chk($sformatf("%s_valid_drop", name), res_valid, 0);
        chk($sformatf("%s_busy_drop", name), busy, 0);
        chk($sformatf("%s_ready_back", name), cmd_ready, 1);
    endtask

    initial begin
        vec_t tbl[8];
        vec_t bp;
        ap_rst_n     = 1'b0;
        cmd_valid    = 1'b0;
        cmd_check    = 1'b0;
        cmd_expected = '0;
        core_ready   = 1'b0;
        core_done    = 1'b0;
        core_idle    = 1'b1;
        core_return  = '0;
        res_ready    = 1'b1;

        //           chk   exp_in        ret           rdy  done  hang  e_data        e_cyc mm    to    starts
        tbl[0] = '{1'b1, 32'h37,       32'h37,       1,   11,   1'b0, 32'h37,       11,   1'b0, 1'b0, 1};
        tbl[1] = '{1'b1, 32'h37,       32'h1234ABCD, 1,   11,   1'b0, 32'h1234ABCD, 11,   1'b1, 1'b0, 1};
        tbl[2] = '{1'b0, 32'h37,       32'h1234ABCD, 1,   11,   1'b0, 32'h1234ABCD, 11,   1'b0, 1'b0, 1};
        tbl[3] = '{1'b0, 32'h0,        32'hFFFFFFFF, 1,   1,    1'b0, 32'hFFFFFFFF, 1,    1'b0, 1'b0, 1};
        tbl[4] = '{1'b1, 32'h5,        32'h5,        3,   7,    1'b0, 32'h5,        7,    1'b0, 1'b0, 3};
        tbl[5] = '{1'b1, 32'h37,       32'h37,       1,   0,    1'b1, 32'h0,        TO,   1'b0, 1'b1, 1};
        tbl[6] = '{1'b1, 32'hAA,       32'hAA,       1,   TO,   1'b0, 32'hAA,       TO,   1'b0, 1'b0, 1};
        tbl[7] = '{1'b0, 32'h0,        32'h0,        0,   0,    1'b1, 32'h0,        TO,   1'b0, 1'b1, TO};
        bp     = '{1'b1, 32'h99,       32'h55,       2,   4,    1'b0, 32'h55,       4,    1'b1, 1'b0, 2};

        repeat (3) cyc();
        chk("rst_core_start", core_start, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_cycles", res_cycles, 0);
        chk("rst_res_flags", {res_mismatch, res_timeout}, 0);
        ap_rst_n = 1'b1;
        cyc();

        for (int i = 0; i < 8; i++) do_vec(tbl[i], $sformatf("v%0d", i));

        // Back-pressure: the result must stay stable and extra done pulses must be ignored.
        res_ready = 1'b0;
        run(bp, "bp");
        for (int i = 0; i < 20; i++) begin
            core_done   = (i == 5) || (i == 12);
            core_ready  = core_done;
            core_return = 32'hBAD00000 + 32'(i);
            cmd_valid   = 1'b1;
            chk("bp_valid", res_valid, 1);
            chk("bp_data", res_data, 32'h55);
            chk("bp_cycles", res_cycles, 4);
            chk("bp_mismatch", res_mismatch, 1);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_core_start", core_start, 0);
            cyc();
        end
        core_done  = 1'b0;
        core_ready = 1'b0;
        cmd_valid  = 1'b0;
        res_ready  = 1'b1;
        chk("bp_hs_cmd_ready", cmd_ready, 0);
        cyc();
        chk("bp_after_valid", res_valid, 0);
        chk("bp_after_cmd_ready", cmd_ready, 1);
        core_idle = 1'b0;
        cmd_valid = 1'b1;
        #1;
        chk("nidle_cmd_ready", cmd_ready, 0);
        repeat (3) begin
            cyc();
            chk("nidle_core_start", core_start, 0);
            chk("nidle_busy", busy, 0);
        end
        cmd_valid = 1'b0;
        core_idle = 1'b1;
        cyc();

        // Reset during WAIT_DONE.
        cmd_valid = 1'b1;
        cyc();
        cmd_valid  = 1'b0;
        core_idle  = 1'b0;
        core_ready = 1'b1;
        cyc();
        core_ready = 1'b0;
        cyc();
        chk("rm_wait_busy", busy, 1);
        chk("rm_wait_start", core_start, 0);
        ap_rst_n = 1'b0;
        #1;
        chk("rm_wait_busy_rst", busy, 0);
        chk("rm_wait_valid_rst", res_valid, 0);
        core_idle = 1'b1;
        cyc();
        ap_rst_n = 1'b1;
        cyc();

        // Reset during START: core_start must drop without waiting for a clock.
        cmd_valid = 1'b1;
        cyc();
        cmd_valid = 1'b0;
        core_idle = 1'b0;
        cyc();
        chk("rm_start_high", core_start, 1);
        ap_rst_n = 1'b0;
        #1;
        chk("rm_start_rst", core_start, 0);
        chk("rm_start_busy_rst", busy, 0);
        chk("rm_start_valid_rst", res_valid, 0);
        core_idle = 1'b1;
        cyc();
        ap_rst_n = 1'b1;
        cyc();
        do_vec(tbl[0], "post_rst");

        repeat (2) cyc();
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
